// File: rtl/wdma_sched_pkg.sv
// Shared definitions for the write-DMA frame scheduler.
//   state_t        : 3-bit FSM encoding S_IDLE..S_DONE
//   ERR_CFG/ERR_TMO: bit positions inside the sticky err vector
//   BEAT_SHIFT     : log2 of the default AXI beat size in bytes
package wdma_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int ERR_CFG        = 0;
    localparam int ERR_TMO        = 1;
    localparam int DEF_BEAT_BYTES = 8;
    localparam int BEAT_SHIFT     = $clog2(DEF_BEAT_BYTES);

endpackage

// File: rtl/start_edge_det.sv
// Registered rising-edge detector.
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   din  in  level input
//   rise out one-cycle pulse, registered, one cycle after din goes 0->1
module start_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        prev_d = din;
        rise_d = din & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/wdma_frame_sched.sv
// Multi-frame sequencer for the write DMA: one accepted ap_start launches
// cfg_num_frames wdma jobs, advancing the write address by cfg_frame_stride.
// Optional feature macro: WDMA_SCHED_TIMEOUT_EN (per-frame wdma timeout).
// Ports:
//   ap_clk/ap_rst            clock, asynchronous active-high reset
//   ap_start/ap_done/ap_idle/ap_ready  run handshake towards control regs
//   cfg_*                    run configuration, latched on accepted start
//   dma_ap_start/dma_ap_done/dma_ap_idle  wdma handshake
//   dma_transfer_byte/dma_write_base_addr  per-frame wdma arguments
//   frame_idx/frame_done     progress (completed frame count, per-frame pulse)
//   err                      sticky [0] bad cfg, [1] timeout
module wdma_frame_sched
    import wdma_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FRAME_W    = 16,
    parameter int BEAT_BYTES = 1 << BEAT_SHIFT,
    parameter int TMO_W      = 24
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [FRAME_W-1:0]    cfg_num_frames,
    input  logic [ADDR_WIDTH-1:0] cfg_frame_bytes,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_frame_stride,
    input  logic [TMO_W-1:0]      cfg_timeout,
    output logic                  dma_ap_start,
    input  logic                  dma_ap_done,
    input  logic                  dma_ap_idle,
    output logic [ADDR_WIDTH-1:0] dma_transfer_byte,
    output logic [ADDR_WIDTH-1:0] dma_write_base_addr,
    output logic [FRAME_W-1:0]    frame_idx,
    output logic                  frame_done,
    output logic [1:0]            err
);

    localparam int BSH = $clog2(BEAT_BYTES);

    // Frame size must be a nonzero whole number of beats.
    function automatic logic bad_frame_bytes(input logic [ADDR_WIDTH-1:0] b);
        return (b == '0) || (((b >> BSH) << BSH) != b);
    endfunction

    state_t                  state_q, state_d;
    logic [FRAME_W-1:0]      num_frames_q, num_frames_d;
    logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   bytes_q, bytes_d;
    logic [FRAME_W-1:0]      frame_idx_q, frame_idx_d;
    logic                    frame_done_q, frame_done_d;
    logic [1:0]              err_q, err_d;
    logic                    start_rise;
    logic                    accept;

`ifdef WDMA_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [TMO_W-1:0]        timeout_q, timeout_d;
    logic                    tmo_hit;
    // Counter holds the number of cycles since the start pulse, so the run
    // ends exactly cfg_timeout cycles after dma_ap_start.
    assign tmo_hit = (timeout_q != '0) &&
                     (({1'b0, tmo_cnt_q} + (TMO_W+1)'(1)) >= {1'b0, timeout_q});
`else
    logic                    unused_cfg_timeout;
    assign unused_cfg_timeout = ^cfg_timeout;
`endif

    start_edge_det u_start_edge (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .din  (ap_start),
        .rise (start_rise)
    );

    assign accept = (state_q == S_IDLE) && start_rise;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= S_IDLE;
            num_frames_q <= '0;
            stride_q     <= '0;
            addr_q       <= '0;
            bytes_q      <= '0;
            frame_idx_q  <= '0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
`ifdef WDMA_SCHED_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            timeout_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            num_frames_q <= num_frames_d;
            stride_q     <= stride_d;
            addr_q       <= addr_d;
            bytes_q      <= bytes_d;
            frame_idx_q  <= frame_idx_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef WDMA_SCHED_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        num_frames_d = num_frames_q;
        stride_d     = stride_q;
        addr_d       = addr_q;
        bytes_d      = bytes_q;
        frame_idx_d  = frame_idx_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
`ifdef WDMA_SCHED_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    num_frames_d = cfg_num_frames;
                    stride_d     = cfg_frame_stride;
                    addr_d       = cfg_base_addr;
                    bytes_d      = cfg_frame_bytes;
                    frame_idx_d  = '0;
                    err_d        = '0;
`ifdef WDMA_SCHED_TIMEOUT_EN
                    timeout_d    = cfg_timeout;
`endif
                    state_d      = S_CHECK;
                end
            end
            S_CHECK: begin
                if (num_frames_q == '0) begin
                    state_d = S_DONE;
                end else if (bad_frame_bytes(bytes_q)) begin
                    err_d[ERR_CFG] = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dma_ap_idle) begin
`ifdef WDMA_SCHED_TIMEOUT_EN
                    tmo_cnt_d = TMO_W'(1);
`endif
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dma_ap_done) begin
                    frame_done_d = 1'b1;
                    frame_idx_d  = frame_idx_q + FRAME_W'(1);
                    addr_d       = addr_q + stride_q;
                    state_d      = ((frame_idx_q + FRAME_W'(1)) == num_frames_q) ? S_DONE : S_GAP;
                end
`ifdef WDMA_SCHED_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            // One idle cycle so wdma sees a fresh rising edge on its start.
            S_GAP:   state_d = S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifndef WDMA_SCHED_TIMEOUT_EN
        err_d[ERR_TMO] = 1'b0;
`endif
    end

    always_comb begin
        ap_idle      = (state_q == S_IDLE);
        ap_ready     = accept;
        ap_done      = (state_q == S_DONE);
        dma_ap_start = (state_q == S_ISSUE) && dma_ap_idle;
    end

    assign dma_transfer_byte   = bytes_q;
    assign dma_write_base_addr = addr_q;
    assign frame_idx           = frame_idx_q;
    assign frame_done          = frame_done_q;
    assign err                 = err_q;

endmodule

// File: tb/tb_wdma_frame_sched.sv
module tb_wdma_frame_sched;

    localparam int AW = 32;
    localparam int FW = 16;
    localparam int TW = 24;
    localparam int DMA_LAT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ap_start = 1'b0;
    logic          ap_done, ap_idle, ap_ready;
    logic [FW-1:0] cfg_num_frames = '0;
    logic [AW-1:0] cfg_frame_bytes = '0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [AW-1:0] cfg_frame_stride = '0;
    logic [TW-1:0] cfg_timeout = '0;
    logic          dma_ap_start;
    logic          dma_ap_done;
    logic          dma_ap_idle;
    logic [AW-1:0] dma_transfer_byte, dma_write_base_addr;
    logic [FW-1:0] frame_idx;
    logic          frame_done;
    logic [1:0]    err;

    int total = 0;
    int bad = 0;

    // scoreboard: expected {address, bytes} per dma start pulse
    logic [63:0] exp_q[$];

    int cyc = 0;
    int n_ready, n_done, n_start, n_fdone;
    int ready_cyc, done_cyc, start_cyc, first_start_cyc, dd_cyc;
    bit have_dd;
    bit prev_start;
    logic [AW-1:0] prev_addr;

    // wdma model
    logic busy;
    int   busy_cnt;
    bit   never_done = 1'b0;

    always #5 clk = ~clk;

    wdma_frame_sched dut (
        .ap_clk              (clk),
        .ap_rst              (rst),
        .ap_start            (ap_start),
        .ap_done             (ap_done),
        .ap_idle             (ap_idle),
        .ap_ready            (ap_ready),
        .cfg_num_frames      (cfg_num_frames),
        .cfg_frame_bytes     (cfg_frame_bytes),
        .cfg_base_addr       (cfg_base_addr),
        .cfg_frame_stride    (cfg_frame_stride),
        .cfg_timeout         (cfg_timeout),
        .dma_ap_start        (dma_ap_start),
        .dma_ap_done         (dma_ap_done),
        .dma_ap_idle         (dma_ap_idle),
        .dma_transfer_byte   (dma_transfer_byte),
        .dma_write_base_addr (dma_write_base_addr),
        .frame_idx           (frame_idx),
        .frame_done          (frame_done),
        .err                 (err)
    );

    assign dma_ap_idle = ~busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            busy_cnt    <= 0;
            dma_ap_done <= 1'b0;
        end else begin
            dma_ap_done <= 1'b0;
            if (!busy && dma_ap_start) begin
                busy     <= 1'b1;
                busy_cnt <= 0;
            end else if (busy) begin
                if (!never_done && busy_cnt == DMA_LAT - 1) begin
                    busy        <= 1'b0;
                    dma_ap_done <= 1'b1;
                end
                busy_cnt <= busy_cnt + 1;
            end
        end
    end

    // monitor: scoreboard pop on every dma start, pulse shape and latency
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_start = 1'b0;
                continue;
            end
            if (ap_ready) begin n_ready++; ready_cyc = cyc; end
            if (ap_done) begin n_done++; done_cyc = cyc; end
            if (frame_done) n_fdone++;
            if (dma_ap_start) begin
                n_start++;
                start_cyc = cyc;
                if (n_start == 1) first_start_cyc = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_start: addr=%h bytes=%h required no start", dma_write_base_addr, dma_transfer_byte);
                end else begin
                    e = exp_q.pop_front();
                    if ({dma_write_base_addr, dma_transfer_byte} !== e) begin
                        bad++;
                        $display("FAIL sb_start_args: got %h required %h", {dma_write_base_addr, dma_transfer_byte}, e);
                    end
                end
                total++;
                if (prev_start !== 1'b0) begin
                    bad++;
                    $display("FAIL start_low_gap: prev_start=%0b required 0", prev_start);
                end
                total++;
                if (prev_addr !== dma_write_base_addr) begin
                    bad++;
                    $display("FAIL addr_setup: prev=%h now=%h required equal", prev_addr, dma_write_base_addr);
                end
                if (have_dd) begin
                    total++;
                    if (cyc - dd_cyc != 2) begin
                        bad++;
                        $display("FAIL done_to_start: got %0d required 2", cyc - dd_cyc);
                    end
                    have_dd = 1'b0;
                end
            end
            if (dma_ap_done) begin have_dd = 1'b1; dd_cyc = cyc; end
            prev_start = dma_ap_start;
            prev_addr  = dma_write_base_addr;
        end
    end

    task automatic clear_counts();
        n_ready = 0; n_done = 0; n_start = 0; n_fdone = 0;
        ready_cyc = 0; done_cyc = 0; start_cyc = 0; first_start_cyc = 0;
        have_dd = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_cfg(input logic [FW-1:0] n, input logic [AW-1:0] b,
                           input logic [AW-1:0] base, input logic [AW-1:0] stride);
        cfg_num_frames   = n;
        cfg_frame_bytes  = b;
        cfg_base_addr    = base;
        cfg_frame_stride = stride;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 ap_start = 1'b1;
        @(posedge clk); #1 ap_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ap_done) begin seen = 1'b1; break; end
        end
        #1;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_ap_done_timeout: ap_done=0 required 1 within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int k = 0; k < budget && n_start < n; k++) @(negedge clk);
        #1;
        total++;
        if (n_start < n) begin
            bad++;
            $display("FAIL wait_start_timeout: starts=%0d required %0d", n_start, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({ap_idle, ap_done, ap_ready, dma_ap_start, frame_done} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 10000", {ap_idle, ap_done, ap_ready, dma_ap_start, frame_done});
        end
        total++;
        if ({dma_write_base_addr, dma_transfer_byte} !== 64'h0) begin
            bad++;
            $display("FAIL reset_dma_regs: got %h required 0", {dma_write_base_addr, dma_transfer_byte});
        end
        total++;
        if ({frame_idx, err} !== 18'h0) begin
            bad++;
            $display("FAIL reset_idx_err: got %h required 0", {frame_idx, err});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_multi_frame();
        clear_counts();
        set_cfg(16'd3, 32'h100, 32'h1000_0000, 32'h400);
        exp_q.push_back({32'h1000_0000, 32'h100});
        exp_q.push_back({32'h1000_0400, 32'h100});
        exp_q.push_back({32'h1000_0800, 32'h100});
        pulse_start();
        wait_done("t1", 500);
        total++;
        if (n_start !== 3 || n_fdone !== 3 || n_ready !== 1) begin
            bad++;
            $display("FAIL t1_counts: starts=%0d fdone=%0d ready=%0d required 3 3 1", n_start, n_fdone, n_ready);
        end
        total++;
        if (first_start_cyc - ready_cyc != 2) begin
            bad++;
            $display("FAIL t1_accept_latency: got %0d required 2", first_start_cyc - ready_cyc);
        end
        total++;
        if (frame_idx !== 16'd3 || err !== 2'b00) begin
            bad++;
            $display("FAIL t1_idx_err: idx=%0d err=%b required 3 00", frame_idx, err);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL t1_sb_left: got %0d entries required 0", exp_q.size());
        end
    endtask

    task automatic test_bad_cfg();
        clear_counts();
        set_cfg(16'd2, 32'h104, 32'h2000, 32'h100);
        pulse_start();
        wait_done("t2", 50);
        total++;
        if (err !== 2'b01) begin
            bad++;
            $display("FAIL t2_err: got %b required 01", err);
        end
        total++;
        if (done_cyc - ready_cyc != 2) begin
            bad++;
            $display("FAIL t2_done_latency: got %0d required 2", done_cyc - ready_cyc);
        end
        total++;
        if (n_start !== 0) begin
            bad++;
            $display("FAIL t2_no_dma: starts=%0d required 0", n_start);
        end
    endtask

    task automatic test_zero_frames();
        clear_counts();
        set_cfg(16'd0, 32'h100, 32'h2000, 32'h100);
        pulse_start();
        wait_done("t3", 50);
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (err !== 2'b00) begin
            bad++;
            $display("FAIL t3_err_cleared: got %b required 00", err);
        end
        total++;
        if (n_start !== 0 || n_done !== 1) begin
            bad++;
            $display("FAIL t3_counts: starts=%0d done=%0d required 0 1", n_start, n_done);
        end
    endtask

    task automatic test_start_level();
        clear_counts();
        set_cfg(16'd2, 32'h40, 32'h2000, 32'h100);
        exp_q.push_back({32'h2000, 32'h40});
        exp_q.push_back({32'h2100, 32'h40});
        @(posedge clk); #1 ap_start = 1'b1;
        wait_starts(1, 50);
        repeat (5) @(posedge clk);
        #1 ap_start = 1'b0;
        @(posedge clk); #1 ap_start = 1'b1;
        wait_done("t4", 300);
        repeat (150) @(posedge clk);
        #1 ap_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (n_ready !== 1 || n_done !== 1 || n_start !== 2) begin
            bad++;
            $display("FAIL t4_single_run: ready=%0d done=%0d starts=%0d required 1 1 2", n_ready, n_done, n_start);
        end
    endtask

    task automatic test_wrap_and_reset();
        clear_counts();
        set_cfg(16'd2, 32'h100, 32'hFFFF_FC00, 32'h400);
        exp_q.push_back({32'hFFFF_FC00, 32'h100});
        exp_q.push_back({32'h0000_0000, 32'h100});
        pulse_start();
        wait_done("t5", 300);
        total++;
        if (n_start !== 2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL t5_wrap_starts: starts=%0d left=%0d required 2 0", n_start, exp_q.size());
        end
        clear_counts();
        set_cfg(16'd3, 32'h80, 32'h3000, 32'h40);
        exp_q.push_back({32'h3000, 32'h80});
        exp_q.push_back({32'h3040, 32'h80});
        exp_q.push_back({32'h3080, 32'h80});
        pulse_start();
        wait_starts(2, 200);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (frame_idx !== 16'd1 || ap_idle !== 1'b0) begin
            bad++;
            $display("FAIL t5_pre_reset: idx=%0d idle=%b required 1 0", frame_idx, ap_idle);
        end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        total++;
        if ({ap_idle, ap_done, ap_ready, dma_ap_start, frame_done} !== 5'b10000) begin
            bad++;
            $display("FAIL t5_async_ctrl: got %b required 10000", {ap_idle, ap_done, ap_ready, dma_ap_start, frame_done});
        end
        total++;
        if ({dma_write_base_addr, dma_transfer_byte, frame_idx, err} !== 82'h0) begin
            bad++;
            $display("FAIL t5_async_regs: got %h required 0", {dma_write_base_addr, dma_transfer_byte, frame_idx, err});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

`ifdef WDMA_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        clear_counts();
        never_done  = 1'b1;
        cfg_timeout = 24'd50;
        set_cfg(16'd3, 32'h100, 32'h4000, 32'h100);
        exp_q.push_back({32'h4000, 32'h100});
        pulse_start();
        wait_done("t6", 300);
        total++;
        if (err !== 2'b10) begin
            bad++;
            $display("FAIL t6_err: got %b required 10", err);
        end
        total++;
        if (done_cyc - start_cyc != 50 || n_start !== 1) begin
            bad++;
            $display("FAIL t6_latency: got %0d starts=%0d required 50 1", done_cyc - start_cyc, n_start);
        end
    endtask
`endif

    initial begin
        clear_counts();
        test_reset();
        test_multi_frame();
        test_bad_cfg();
        test_zero_frames();
        test_start_level();
        test_wrap_and_reset();
`ifdef WDMA_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
